// File: rtl/vend_sched.sv
// vend_sched: round-robin arbiter sharing one product motor and change hopper among NREQ vending panels
module vend_sched #(
  parameter int NREQ       = 4,
  parameter int TIMEOUT    = 255,
  parameter int STOCK_W    = 8,
  parameter int STOCK_INIT = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    chg_i,
  input  logic               refill_i,
  input  logic [STOCK_W-1:0] refill_cnt_i,
  output logic               disp_start_o,
  input  logic               disp_done_i,
  output logic               chg_start_o,
  input  logic               chg_done_i,
  output logic [NREQ-1:0]    ack_o,
  output logic               err_o,
  output logic               busy_o,
  output logic               empty_o,
  output logic               fault_o,
  output logic [STOCK_W-1:0] stock_o
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 2);
  typedef enum logic [2:0] {IDLE, DISP, CHG, ACK, FAULT} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, g_q, g_d, gnt, idx;
  logic gchg_q, gchg_d, errq_q, errq_d, fault_q, fault_d, found, tmo, acking;
  logic [TW-1:0] timer_q, timer_d;
  logic [STOCK_W-1:0] stock_q, stock_d;
  always_comb begin
    found = 1'b0;
    gnt = ptr_q;
    idx = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr_q) + i) % NREQ);
      if (req_i[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  assign tmo = timer_q == TW'(TIMEOUT);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    g_d = g_q;
    gchg_d = gchg_q;
    errq_d = errq_q;
    stock_d = stock_q;
    fault_d = fault_q;
    timer_d = (state_q == DISP || state_q == CHG) ? timer_q + 1'b1 : '0;
    case (state_q)
      IDLE:
        if (refill_i) stock_d = refill_cnt_i;
        else if (found) begin
          g_d = gnt;
          gchg_d = chg_i[gnt];
          errq_d = stock_q == '0;
          state_d = (stock_q == '0) ? ACK : DISP;
        end
      DISP:
        if (disp_done_i) begin
          stock_d = stock_q - 1'b1;
          errq_d = 1'b0;
          state_d = gchg_q ? CHG : ACK;
        end else if (tmo) state_d = FAULT;
      CHG:
        if (chg_done_i) begin
          errq_d = 1'b0;
          state_d = ACK;
        end else if (tmo) state_d = FAULT;
      ACK: begin
        ptr_d = (g_q == PW'(NREQ - 1)) ? '0 : g_q + 1'b1;
        state_d = IDLE;
      end
      FAULT:
        if (refill_i) begin
          stock_d = refill_cnt_i;
          fault_d = 1'b0;
          state_d = IDLE;
        end else fault_d = 1'b1;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      g_q <= '0;
      gchg_q <= 1'b0;
      errq_q <= 1'b0;
      timer_q <= '0;
      stock_q <= STOCK_W'(STOCK_INIT);
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      g_q <= g_d;
      gchg_q <= gchg_d;
      errq_q <= errq_d;
      timer_q <= timer_d;
      stock_q <= stock_d;
      fault_q <= fault_d;
    end
  assign acking = state_q == ACK || (state_q == FAULT && !fault_q);
  assign ack_o = acking ? NREQ'(1) << g_q : '0;
  assign err_o = acking && (state_q == FAULT || errq_q);
  assign disp_start_o = state_q == DISP && timer_q == '0;
  assign chg_start_o = state_q == CHG && timer_q == '0;
  assign busy_o = state_q != IDLE;
  assign empty_o = stock_q == '0;
  assign fault_o = fault_q;
  assign stock_o = stock_q;
endmodule

// File: tb/tb_vend_sched.sv
// tb_vend_sched: transaction-timeline model of vend_sched driven by random and directed purchases
module tb_vend_sched;
  localparam int N = 4, TO = 15, SW = 8, SI = 20;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req_i = '0, chg_i = '0;
  logic refill_i = 1'b0, disp_done_i = 1'b0, chg_done_i = 1'b0;
  logic [SW-1:0] refill_cnt_i = '0;
  logic disp_start_o, chg_start_o, err_o, busy_o, empty_o, fault_o;
  logic [N-1:0] ack_o;
  logic [SW-1:0] stock_o;
  int checks = 0, errors = 0, m_stock = SI, m_ptr = 0, tx = 0;
  logic m_fault = 1'b0;
  logic [N-1:0] reqv = '0;
  always #5 clk = ~clk;
  vend_sched #(.NREQ(N), .TIMEOUT(TO), .STOCK_W(SW), .STOCK_INIT(SI)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .chg_i(chg_i), .refill_i(refill_i),
    .refill_cnt_i(refill_cnt_i), .disp_start_o(disp_start_o), .disp_done_i(disp_done_i),
    .chg_start_o(chg_start_o), .chg_done_i(chg_done_i), .ack_o(ack_o), .err_o(err_o),
    .busy_o(busy_o), .empty_o(empty_o), .fault_o(fault_o), .stock_o(stock_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check_outs(input string tag, input logic ds, input logic cs, input logic [N-1:0] ack, input logic err, input logic busy);
    check({tag, " disp_start"}, disp_start_o, ds);
    check({tag, " chg_start"}, chg_start_o, cs);
    check({tag, " ack"}, ack_o, ack);
    check({tag, " err"}, err_o, err);
    check({tag, " busy"}, busy_o, busy);
    check({tag, " fault"}, fault_o, m_fault);
    check({tag, " stock"}, stock_o, m_stock);
    check({tag, " empty"}, empty_o, m_stock == 0);
  endtask
  function automatic int pick();
    int r;
    r = $urandom_range(0, 19);
    return r == 0 ? TO + 1 : r == 1 ? TO : $urandom_range(0, 3);
  endfunction
  task automatic vend(input int dl, input int cl, input logic [N-1:0] chgv, input logic drop, output logic f);
    int g, k, tc, m, ta;
    logic gc, served, dph, cph;
    string tag;
    tx++;
    req_i = reqv;
    chg_i = chgv;
    g = -1;
    for (int i = 0; i < N; i++) if (g < 0 && reqv[(m_ptr + i) % N]) g = (m_ptr + i) % N;
    gc = chgv[g];
    served = m_stock > 0;
    k = -1;
    tc = -1;
    m = -1;
    if (!served) ta = 1;
    else if (dl > TO) ta = TO + 2;
    else begin
      k = 1 + dl;
      if (!gc) ta = k + 1;
      else begin
        tc = k + 1;
        if (cl > TO) ta = tc + TO + 1;
        else begin
          m = tc + cl;
          ta = m + 1;
        end
      end
    end
    f = served && (k < 0 || (gc && m < 0));
    for (int c = 1; c <= ta; c++) begin
      step;
      disp_done_i = 1'b0;
      chg_done_i = 1'b0;
      refill_i = 1'b0;
      if (k >= 0 && c == k + 1) m_stock--;
      tag = $sformatf("tx%0d c%0d", tx, c);
      check_outs(tag, c == 1 && served, c == tc, c == ta ? N'(1) << g : '0, c == ta && (f || !served), 1'b1);
      if (c < ta) begin
        dph = served && (k < 0 || c <= k);
        cph = tc > 0 && c >= tc;
        chg_i = N'($urandom);
        if (dph) chg_done_i = $urandom_range(0, 3) == 0;
        if (cph) disp_done_i = $urandom_range(0, 3) == 0;
        if (c == k) disp_done_i = 1'b1;
        if (c == m) chg_done_i = 1'b1;
        refill_i = $urandom_range(0, 4) == 0;
        refill_cnt_i = SW'($urandom);
        if (drop && c == 1) reqv[g] = 1'b0;
        req_i = reqv;
      end
    end
    if (!f) m_ptr = (g + 1) % N;
    reqv[g] = 1'b0;
    req_i = reqv;
  endtask
  task automatic settle(input logic f, input int cnt);
    if (f) begin
      for (int i = 0; i < 3; i++) begin
        step;
        m_fault = 1'b1;
        check_outs($sformatf("tx%0d hold%0d", tx, i), 1'b0, 1'b0, '0, 1'b0, 1'b1);
        req_i = N'($urandom_range(1, 15));
      end
      req_i = reqv;
      refill_i = 1'b1;
      refill_cnt_i = SW'(cnt);
      step;
      refill_i = 1'b0;
      m_stock = cnt;
      m_fault = 1'b0;
      check_outs($sformatf("tx%0d recover", tx), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    end else begin
      step;
      check_outs($sformatf("tx%0d idle", tx), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
  endtask
  task automatic refill(input int cnt);
    refill_i = 1'b1;
    refill_cnt_i = SW'(cnt);
    req_i = reqv;
    step;
    refill_i = 1'b0;
    m_stock = cnt;
    check_outs("refill", 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask
  initial begin
    logic f;
    int dl, cl;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;
    step;
    check_outs("released", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    reqv = 4'b0010;
    vend(3, 0, 4'b0000, 1'b0, f);
    settle(f, 0);
    reqv = 4'b0001;
    vend(2, 2, 4'b0001, 1'b0, f);
    settle(f, 0);
    reqv = 4'b1000;
    vend(0, 0, 4'b0000, 1'b0, f);
    settle(f, 0);
    for (int r = 0; r < 2; r++) begin
      reqv = 4'b1111;
      for (int i = 0; i < N; i++) begin
        vend(0, 0, 4'b0000, 1'b0, f);
        settle(f, 0);
      end
      reqv = 4'b0010;
      vend(0, 0, 4'b0000, 1'b0, f);
      settle(f, 0);
    end
    refill(1);
    reqv = 4'b0001;
    vend(0, 0, 4'b0000, 1'b0, f);
    settle(f, 0);
    reqv = 4'b0010;
    vend(0, 0, 4'b0000, 1'b0, f);
    settle(f, 0);
    refill(10);
    reqv = 4'b0100;
    vend(TO + 1, 0, 4'b0000, 1'b0, f);
    settle(f, 5);
    reqv = 4'b0100;
    vend(TO, TO, 4'b1111, 1'b0, f);
    settle(f, 0);
    reqv = 4'b1000;
    vend(0, TO + 1, 4'b1111, 1'b0, f);
    settle(f, 8);
    reqv = 4'b0001;
    req_i = reqv;
    chg_i = 4'b0001;
    step;
    check_outs("rchg c1", 1'b1, 1'b0, '0, 1'b0, 1'b1);
    disp_done_i = 1'b1;
    step;
    disp_done_i = 1'b0;
    m_stock--;
    check_outs("rchg c2", 1'b0, 1'b1, '0, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    m_stock = SI;
    m_ptr = 0;
    check_outs("rst in chg", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    reqv = '0;
    req_i = '0;
    @(negedge clk) rst = 1'b1;
    step;
    check_outs("after rst", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    reqv = 4'b0001;
    vend(1, 1, 4'b0001, 1'b0, f);
    settle(f, 0);
    for (int t = 0; t < 150; t++) begin
      if (reqv == '0) reqv = N'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) refill($urandom_range(0, 3));
      dl = pick();
      cl = pick();
      vend(dl, cl, N'($urandom), $urandom_range(0, 3) == 0, f);
      settle(f, $urandom_range(1, 6));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_sched.md
# vend_sched

Round-robin scheduler that shares one dispense mechanism (product motor plus change hopper) among NREQ coin/purchase panels, each running its own vending FSM. It grants one panel at a time, sequences the dispense and optional change-return handshakes, tracks remaining stock, and reports per-transaction completion or error. It sits between the panel FSMs and the shared dispenser driver.

## Interface
- NREQ, 4, number of requesting panels (2..8)
- TIMEOUT, 255, max cycles to wait for a done after a start
- STOCK_W, 8, stock counter width
- STOCK_INIT, 20, stock value loaded at reset

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-panel vend request, held until ack
- chg  in  NREQ  per-panel "change owed" flag, valid while req high
- refill  in  1  service pulse: load stock, clear fault
- refill_cnt  in  STOCK_W  stock value loaded on refill
- disp_start  out  1  one-cycle pulse to the product motor
- disp_done  in  1  product dispensed
- chg_start  out  1  one-cycle pulse to the change hopper
- chg_done  in  1  change returned
- ack  out  NREQ  one-hot, one-cycle completion strobe to the granted panel
- err  out  1  qualifies ack: 1 = not served (empty or fault)
- busy  out  1  state != IDLE
- empty  out  1  stock == 0
- fault  out  1  sticky dispenser-timeout flag
- stock  out  STOCK_W  current stock count

## Operation
- States: IDLE, DISP, CHG, ACK, FAULT.
- Registers: state, ptr (round-robin base, 0..NREQ-1), g (granted index), gchg (latched chg[g]), errq, timer, stock, fault.
- IDLE:
  - refill=1 has priority: stock <= refill_cnt, stay IDLE, no grant that cycle.
  - Otherwise, if any req is high: g = first set bit searching ptr, ptr+1, ... wrapping modulo NREQ; gchg <= chg[g].
    - stock>0: go to DISP.
    - stock==0: errq <= 1, go to ACK (no dispense).
- DISP:
  - disp_start=1 in the first cycle only.
  - disp_done=1: stock <= stock-1; go to CHG if gchg, else ACK with errq=0.
  - timer==TIMEOUT with disp_done=0: go to FAULT.
- CHG:
  - chg_start=1 in the first cycle only.
  - chg_done=1: go to ACK, errq=0.
  - Timeout: FAULT (stock already decremented, not restored).
- ACK:
  - ack[g]=1 and err=errq for exactly one cycle.
  - ptr <= (g+1) mod NREQ; go to IDLE.
- FAULT:
  - First cycle: ack[g]=1 with err=1; fault <= 1.
  - Then hold with all outputs idle, ignoring req.
  - refill=1: stock <= refill_cnt, fault <= 0, go to IDLE.
- refill is sampled only in IDLE and FAULT; it is ignored in DISP, CHG and ACK.
- req and chg are sampled only in IDLE. A panel dropping req after grant does not abort the transaction; the ack is still issued.
- done inputs are ignored outside their state. A done arriving in the start cycle is accepted.
- empty and busy are combinational from registers.
- Stock never underflows, because a grant requires stock>0.

## Timing
- Reset values: state IDLE, ptr 0, g 0, stock STOCK_INIT, fault 0; disp_start, chg_start, ack, err, busy all 0; empty = (STOCK_INIT==0).
- Latency: req high in IDLE at cycle 0 → disp_start at cycle 1.
  - disp_done at cycle k → ack at k+1 (no change owed).
  - With change: chg_start at k+1, chg_done at m, ack at m+1.
- Empty case: req at cycle 0 → ack with err=1 at cycle 1.
- Timer clears on every state entry and increments each cycle in DISP/CHG. FAULT is entered on the cycle after timer==TIMEOUT with no done, so done must arrive within TIMEOUT+1 cycles of start, counting the start cycle.
- Panel handshake: the panel registers ack and clears req at the clock edge that ends the ack cycle. The scheduler is back in IDLE at that edge, so the next grant comes 2 cycles after ack at the earliest.
- Reset mid-transaction (any state): immediate return to IDLE with reset values. No ack is issued and stock reverts to STOCK_INIT.
- disp_done and chg_done high together: only the one matching the current state is used.

## Test plan
- Single vend, no change: stock=20, req[1]=1, chg[1]=0, disp_done 3 cycles after disp_start → disp_start at cycle 1, ack=4'b0010 with err=0 at cycle 5, stock=19, ptr=2.
- Change path: req[0]=1, chg[0]=1, dispenser and hopper each answer in 2 cycles → disp_start, then chg_start the cycle after disp_done, ack[0] with err=0 the cycle after chg_done.
- Round-robin: req=4'b1111 held, each panel drops req on its ack, all dones immediate → grant order 0,1,2,3; a second round starting with ptr=2 grants 2,3,0,1.
- Empty: refill with refill_cnt=1, two vends → first served with err=0, second acked with err=1 one cycle after req, no disp_start, empty=1, stock=0.
- Timeout: TIMEOUT=15, disp_done held low → ack[g] with err=1, fault=1; further req ignored; refill with refill_cnt=5 → fault=0, IDLE, stock=5.
- Async reset asserted in CHG → outputs zero immediately, stock=STOCK_INIT, no ack; after release a new req is served normally.
